// File: rtl/mem_arb_pkg.sv
// Shared types for the cache-line AXI4-Lite arbiter.
package mem_arb_pkg;

  localparam int unsigned AXI_RESP_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WB_ADDR,
    WB_RESP,
    DONE
  } t_arb_state;

  typedef enum logic [1:0] {
    G_NONE = 2'b00,
    G_RD_I = 2'b01,
    G_RD_D = 2'b10,
    G_WB   = 2'b11
  } t_grant;

  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_line_arbiter_prio_enc.sv
// Fixed-priority encoder for the three line requesters: wb > rd_d > rd_i.
module line_req_prio_enc
  import mem_arb_pkg::*;
(
  input  logic   i_req_rd_i,
  input  logic   i_req_rd_d,
  input  logic   i_req_wb,
  output t_grant o_grant_c
);

  // Highest-priority active request wins.
  always_comb begin
    o_grant_c = G_NONE;
    if (i_req_wb) begin
      o_grant_c = G_WB;
    end else if (i_req_rd_d) begin
      o_grant_c = G_RD_D;
    end else if (i_req_rd_i) begin
      o_grant_c = G_RD_I;
    end
  end

endmodule

// File: rtl/axi_line_arbiter.sv
// Shares one AXI4-Lite master between I-fill, D-fill and D write-back,
// turning each granted line into WORDS_PER_LINE single-beat transactions.
// During write-back the word index advances when the W beat is accepted, so
// the D-cache already presents the next word when the B response arrives and
// that word can be latched straight into o_wdata.
module axi_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 16
) (
  input  logic                                i_clk,
  input  logic                                i_arst,
  input  logic                                i_req_rd_i,
  input  logic                                i_req_rd_d,
  input  logic                                i_req_wb,
  input  logic [ADDR_WIDTH-1:0]               i_addr_i,
  input  logic [ADDR_WIDTH-1:0]               i_addr_d,
  input  logic [ADDR_WIDTH-1:0]               i_addr_wb,
  input  logic [DATA_WIDTH-1:0]               i_wb_word,
  output logic [$clog2(WORDS_PER_LINE)-1:0]   o_word_idx,
  output logic [DATA_WIDTH-1:0]               o_rd_word,
  output logic                                o_rd_word_valid,
  output logic [1:0]                          o_grant,
  output logic                                o_done,
  output logic                                o_resp_err,
  output logic [ADDR_WIDTH-1:0]               o_awaddr,
  output logic                                o_awvalid,
  input  logic                                i_awready,
  output logic [DATA_WIDTH-1:0]               o_wdata,
  output logic [DATA_WIDTH/8-1:0]             o_wstrb,
  output logic                                o_wvalid,
  input  logic                                i_wready,
  input  logic [1:0]                          i_bresp,
  input  logic                                i_bvalid,
  output logic                                o_bready,
  output logic [ADDR_WIDTH-1:0]               o_araddr,
  output logic                                o_arvalid,
  input  logic                                i_arready,
  input  logic [DATA_WIDTH-1:0]               i_rdata,
  input  logic [1:0]                          i_rresp,
  input  logic                                i_rvalid,
  output logic                                o_rready
);

  localparam int unsigned IDX_W          = $clog2(WORDS_PER_LINE);
  localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int unsigned LINE_OFF_W     = $clog2(WORDS_PER_LINE * BYTES_PER_WORD);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << LINE_OFF_W;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);

  t_arb_state state_q, state_nxt;
  t_grant     grant_q, grant_nxt, grant_c;

  logic [ADDR_WIDTH-1:0] base_q, base_nxt, req_addr_c;
  logic [ADDR_WIDTH-1:0] araddr_nxt, awaddr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt, rd_word_nxt;
  logic [IDX_W-1:0]      idx_nxt;
  logic arvalid_nxt, awvalid_nxt, wvalid_nxt, bready_nxt, rready_nxt;
  logic rd_valid_nxt, done_nxt, err_nxt;
  logic aw_hs_c, w_hs_c;

  // Byte address of a word within the granted line; wraps at ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [IDX_W-1:0]      idx);
    return base + ADDR_WIDTH'(idx) * ADDR_WIDTH'(BYTES_PER_WORD);
  endfunction

  line_req_prio_enc u_prio_enc (
    .i_req_rd_i (i_req_rd_i),
    .i_req_rd_d (i_req_rd_d),
    .i_req_wb   (i_req_wb),
    .o_grant_c  (grant_c)
  );

  assign o_grant = grant_q;
  assign o_wstrb = '1;
  assign aw_hs_c = o_awvalid & i_awready;
  assign w_hs_c  = o_wvalid & i_wready;

  // Line-aligned address of the requester that would be granted.
  always_comb begin
    unique case (grant_c)
      G_WB:    req_addr_c = i_addr_wb & LINE_MASK;
      G_RD_D:  req_addr_c = i_addr_d & LINE_MASK;
      default: req_addr_c = i_addr_i & LINE_MASK;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state_q;
    grant_nxt    = grant_q;
    base_nxt     = base_q;
    idx_nxt      = o_word_idx;
    araddr_nxt   = o_araddr;
    awaddr_nxt   = o_awaddr;
    wdata_nxt    = o_wdata;
    rd_word_nxt  = o_rd_word;
    arvalid_nxt  = o_arvalid;
    awvalid_nxt  = o_awvalid;
    wvalid_nxt   = o_wvalid;
    bready_nxt   = o_bready;
    rready_nxt   = o_rready;
    err_nxt      = o_resp_err;
    rd_valid_nxt = 1'b0;
    done_nxt     = 1'b0;

    unique case (state_q)
      IDLE: begin
        err_nxt = 1'b0;
        idx_nxt = '0;
        if (grant_c != G_NONE) begin
          grant_nxt = grant_c;
          base_nxt  = req_addr_c;
          if (grant_c == G_WB) begin
            state_nxt   = WB_ADDR;
            awaddr_nxt  = req_addr_c;
            wdata_nxt   = i_wb_word;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
          end else begin
            state_nxt   = RD_ADDR;
            araddr_nxt  = req_addr_c;
            arvalid_nxt = 1'b1;
          end
        end
      end

      RD_ADDR: begin
        if (i_arready) begin
          state_nxt   = RD_DATA;
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
        end
      end

      RD_DATA: begin
        if (i_rvalid) begin
          rready_nxt   = 1'b0;
          rd_word_nxt  = i_rdata;
          rd_valid_nxt = 1'b1;
          idx_nxt      = o_word_idx + IDX_W'(1);
          if (i_rresp != AXI_RESP_OKAY) begin
            err_nxt = 1'b1;
          end
          if (o_word_idx == LAST_IDX) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt   = RD_ADDR;
            arvalid_nxt = 1'b1;
            araddr_nxt  = beat_addr(base_q, o_word_idx + IDX_W'(1));
          end
        end
      end

      WB_ADDR: begin
        if (aw_hs_c) begin
          awvalid_nxt = 1'b0;
        end
        if (w_hs_c) begin
          wvalid_nxt = 1'b0;
          idx_nxt    = o_word_idx + IDX_W'(1);
        end
        if ((!o_awvalid || aw_hs_c) && (!o_wvalid || w_hs_c)) begin
          state_nxt  = WB_RESP;
          bready_nxt = 1'b1;
        end
      end

      WB_RESP: begin
        if (i_bvalid) begin
          bready_nxt = 1'b0;
          if (i_bresp != AXI_RESP_OKAY) begin
            err_nxt = 1'b1;
          end
          // Index already wrapped to 0 after the last W beat.
          if (o_word_idx == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt   = WB_ADDR;
            awaddr_nxt  = beat_addr(base_q, o_word_idx);
            wdata_nxt   = i_wb_word;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
          end
        end
      end

      DONE: begin
        grant_nxt = G_NONE;
        err_nxt   = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q         <= IDLE;
      grant_q         <= G_NONE;
      base_q          <= '0;
      o_word_idx      <= '0;
      o_araddr        <= '0;
      o_awaddr        <= '0;
      o_wdata         <= '0;
      o_rd_word       <= '0;
      o_arvalid       <= 1'b0;
      o_awvalid       <= 1'b0;
      o_wvalid        <= 1'b0;
      o_bready        <= 1'b0;
      o_rready        <= 1'b0;
      o_rd_word_valid <= 1'b0;
      o_done          <= 1'b0;
      o_resp_err      <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      grant_q         <= grant_nxt;
      base_q          <= base_nxt;
      o_word_idx      <= idx_nxt;
      o_araddr        <= araddr_nxt;
      o_awaddr        <= awaddr_nxt;
      o_wdata         <= wdata_nxt;
      o_rd_word       <= rd_word_nxt;
      o_arvalid       <= arvalid_nxt;
      o_awvalid       <= awvalid_nxt;
      o_wvalid        <= wvalid_nxt;
      o_bready        <= bready_nxt;
      o_rready        <= rready_nxt;
      o_rd_word_valid <= rd_valid_nxt;
      o_done          <= done_nxt;
      o_resp_err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_axi_line_arbiter.sv
// Directed bench for axi_line_arbiter with a reactive AXI4-Lite slave model.
module tb_axi_line_arbiter;

  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 32;
  localparam int unsigned WPL = 16;

  logic          clk = 1'b0;
  logic          arst;
  logic          req_rd_i, req_rd_d, req_wb;
  logic [AW-1:0] addr_i, addr_d, addr_wb;
  logic [DW-1:0] wb_word;
  logic [3:0]    word_idx;
  logic [DW-1:0] rd_word;
  logic          rd_word_valid;
  logic [1:0]    grant;
  logic          done, resp_err;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration (written by the test tasks only)
  int ar_wait = 0, aw_wait = 0, w_wait = 0, err_beat = -1;
  // Slave / monitor state (written by the slave process only)
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_beat = 0, aw_hi = 0, w_hi = 0;
  logic [AW-1:0] last_ar = '0;
  logic [AW-1:0] ar_q[$];
  logic [AW-1:0] aw_q[$];
  logic [DW-1:0] w_q[$];
  logic [DW-1:0] rdw_q[$];

  always #5 clk = ~clk;

  // D-cache line model: word k of the write-back line is C0DE_00kk.
  assign wb_word = 32'hC0DE_0000 | 32'(word_idx);

  function automatic logic [DW-1:0] rd_pattern(input logic [AW-1:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  axi_line_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL)) dut (
    .i_clk(clk), .i_arst(arst),
    .i_req_rd_i(req_rd_i), .i_req_rd_d(req_rd_d), .i_req_wb(req_wb),
    .i_addr_i(addr_i), .i_addr_d(addr_d), .i_addr_wb(addr_wb),
    .i_wb_word(wb_word), .o_word_idx(word_idx),
    .o_rd_word(rd_word), .o_rd_word_valid(rd_word_valid),
    .o_grant(grant), .o_done(done), .o_resp_err(resp_err),
    .o_awaddr(awaddr), .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wvalid(wvalid), .i_wready(wready),
    .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_araddr(araddr), .o_arvalid(arvalid), .i_arready(arready),
    .i_rdata(rdata), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(rready)
  );

  // Slave and monitor: react on the falling edge to the registered DUT outputs.
  always @(negedge clk) begin
    if (arst) begin
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    end else begin
      if (rd_word_valid) rdw_q.push_back(rd_word);
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      arready = 1'b0;
      if (arvalid) begin
        if (ar_cnt >= ar_wait) begin
          arready = 1'b1; ar_cnt = 0; ar_q.push_back(araddr); last_ar = araddr;
        end else ar_cnt++;
      end
      rvalid = rready;
      if (rready) begin
        rdata = rd_pattern(last_ar);
        rresp = (r_beat == err_beat) ? 2'b10 : 2'b00;
        r_beat++;
      end
      awready = 1'b0;
      if (awvalid) begin
        if (aw_cnt >= aw_wait) begin
          awready = 1'b1; aw_cnt = 0; aw_q.push_back(awaddr);
        end else aw_cnt++;
      end
      wready = 1'b0;
      if (wvalid) begin
        if (w_cnt >= w_wait) begin
          wready = 1'b1; w_cnt = 0; w_q.push_back(wdata);
        end else w_cnt++;
      end
      bvalid = bready;
      bresp  = 2'b00;
    end
  end

  task automatic wait_done(input int budget, output int cycles, output bit seen);
    seen = 1'b0; cycles = 0;
    while (!seen && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", grant); end
    n_checks++; if (word_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", word_idx); end
    n_checks++; if ({arvalid, awvalid, wvalid, bready, rready} !== 5'b0) begin n_fail++;
      $display("FAIL reset_valids: got %b expected 00000", {arvalid, awvalid, wvalid, bready, rready}); end
    n_checks++; if ({done, resp_err, rd_word_valid} !== 3'b0) begin n_fail++;
      $display("FAIL reset_flags: got %b expected 000", {done, resp_err, rd_word_valid}); end
    n_checks++; if (araddr !== '0 || awaddr !== '0 || wdata !== '0) begin n_fail++;
      $display("FAIL reset_regs: got ar=%h aw=%h wd=%h expected all 0", araddr, awaddr, wdata); end
    @(posedge clk); #2 arst = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (grant !== 2'b00 || arvalid !== 1'b0) begin n_fail++;
      $display("FAIL idle_after_reset: got grant=%b arvalid=%b expected 00/0", grant, arvalid); end
  endtask

  task automatic test_read_line();
    int s_ar, s_rd, cyc; bit seen;
    @(posedge clk); #1;
    s_ar = ar_q.size(); s_rd = rdw_q.size();
    addr_i = 64'h1040; req_rd_i = 1'b1;
    wait_done(200, cyc, seen);
    // Request cycle is cycle 1; done lands in cycle 34, i.e. 33 edges later.
    n_checks++; if (!seen || cyc != 33) begin n_fail++; $display("FAIL read_latency: got %0d edges (seen=%0d) expected 33", cyc, seen); end
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL read_grant: got %b expected 01", grant); end
    req_rd_i = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || grant !== 2'b00) begin n_fail++;
      $display("FAIL read_done_pulse: got done=%b grant=%b expected 0/00", done, grant); end
    @(posedge clk); #1;
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL read_no_regrant: got arvalid=%b expected 0", arvalid); end
    n_checks++; if (ar_q.size() - s_ar != 16) begin n_fail++; $display("FAIL read_ar_count: got %0d expected 16", ar_q.size() - s_ar); end
    n_checks++; if (rdw_q.size() - s_rd != 16) begin n_fail++; $display("FAIL read_strobes: got %0d expected 16", rdw_q.size() - s_rd); end
    for (int k = 0; k < 16; k++) begin
      logic [AW-1:0] ea;
      ea = 64'h1040 + 64'(4 * k);
      n_checks++;
      if (s_ar + k >= ar_q.size() || ar_q[s_ar + k] !== ea) begin n_fail++;
        $display("FAIL read_araddr[%0d]: got %h expected %h", k, (s_ar + k < ar_q.size()) ? ar_q[s_ar + k] : 'x, ea); end
      n_checks++;
      if (s_rd + k >= rdw_q.size() || rdw_q[s_rd + k] !== rd_pattern(ea)) begin n_fail++;
        $display("FAIL read_word[%0d]: got %h expected %h", k, (s_rd + k < rdw_q.size()) ? rdw_q[s_rd + k] : 'x, rd_pattern(ea)); end
    end
  endtask

  task automatic test_priority();
    int cyc, extra, s_aw, s_w; bit seen;
    logic [1:0] exp_g;
    @(posedge clk); #1;
    s_aw = aw_q.size(); s_w = w_q.size();
    addr_i = 64'h2000; addr_d = 64'h3000; addr_wb = 64'h4000;
    req_rd_i = 1'b1; req_rd_d = 1'b1; req_wb = 1'b1;
    for (int n = 0; n < 3; n++) begin
      exp_g = (n == 0) ? 2'b11 : (n == 1) ? 2'b10 : 2'b01;
      wait_done(200, cyc, seen);
      n_checks++; if (!seen || grant !== exp_g) begin n_fail++;
        $display("FAIL prio_grant[%0d]: got %b (seen=%0d) expected %b", n, grant, seen, exp_g); end
      case (grant)
        2'b11:   req_wb   = 1'b0;
        2'b10:   req_rd_d = 1'b0;
        2'b01:   req_rd_i = 1'b0;
        default: begin req_wb = 1'b0; req_rd_d = 1'b0; req_rd_i = 1'b0; end
      endcase
      if (!seen) begin req_wb = 1'b0; req_rd_d = 1'b0; req_rd_i = 1'b0; end
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL prio_done_width[%0d]: got %b expected 0", n, done); end
    end
    extra = 0;
    repeat (10) begin @(posedge clk); #1; if (done) extra++; end
    n_checks++; if (extra != 0 || grant !== 2'b00) begin n_fail++;
      $display("FAIL prio_extra_done: got %0d extra, grant=%b expected 0/00", extra, grant); end
    n_checks++; if (aw_q.size() - s_aw != 16 || w_q.size() - s_w != 16) begin n_fail++;
      $display("FAIL prio_wb_beats: got aw=%0d w=%0d expected 16/16", aw_q.size() - s_aw, w_q.size() - s_w); end
  endtask

  task automatic test_wb_delay();
    int cyc, s_aw, s_w, s_awhi, s_whi; bit seen;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(posedge clk); #1;
    aw_wait = 2; w_wait = 0;
    s_aw = aw_q.size(); s_w = w_q.size(); s_awhi = aw_hi; s_whi = w_hi;
    addr_wb = 64'h0000_0001_0000_0208; req_wb = 1'b1;
    wait_done(400, cyc, seen);
    // 1 grant edge + 16 words x (3 AW cycles + 1 B cycle).
    n_checks++; if (!seen || cyc != 65) begin n_fail++; $display("FAIL wb_latency: got %0d edges (seen=%0d) expected 65", cyc, seen); end
    n_checks++; if (grant !== 2'b11) begin n_fail++; $display("FAIL wb_grant: got %b expected 11", grant); end
    req_wb = 1'b0;
    n_checks++; if (aw_hi - s_awhi != 48) begin n_fail++; $display("FAIL wb_awvalid_cycles: got %0d expected 48", aw_hi - s_awhi); end
    n_checks++; if (w_hi - s_whi != 16) begin n_fail++; $display("FAIL wb_wvalid_cycles: got %0d expected 16", w_hi - s_whi); end
    n_checks++; if (wstrb !== 4'hF) begin n_fail++; $display("FAIL wb_wstrb: got %h expected f", wstrb); end
    for (int k = 0; k < 16; k++) begin
      ea = 64'h0000_0001_0000_0200 + 64'(4 * k);
      ed = 32'hC0DE_0000 | 32'(k);
      n_checks++;
      if (s_aw + k >= aw_q.size() || aw_q[s_aw + k] !== ea) begin n_fail++;
        $display("FAIL wb_awaddr[%0d]: got %h expected %h", k, (s_aw + k < aw_q.size()) ? aw_q[s_aw + k] : 'x, ea); end
      n_checks++;
      if (s_w + k >= w_q.size() || w_q[s_w + k] !== ed) begin n_fail++;
        $display("FAIL wb_wdata[%0d]: got %h expected %h", k, (s_w + k < w_q.size()) ? w_q[s_w + k] : 'x, ed); end
    end
    aw_wait = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_rresp_err();
    int cyc, s_ar; bit seen;
    @(posedge clk); #1;
    s_ar = ar_q.size();
    err_beat = r_beat + 7;
    addr_d = 64'h5000; req_rd_d = 1'b1;
    wait_done(200, cyc, seen);
    n_checks++; if (!seen || resp_err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b (seen=%0d) expected 1", resp_err, seen); end
    n_checks++; if (ar_q.size() - s_ar != 16) begin n_fail++; $display("FAIL err_beats: got %0d expected 16", ar_q.size() - s_ar); end
    req_rd_d = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL err_clear_idle: got %b expected 0", resp_err); end
    addr_i = 64'h6000; req_rd_i = 1'b1;
    wait_done(200, cyc, seen);
    n_checks++; if (!seen || resp_err !== 1'b0) begin n_fail++; $display("FAIL err_next_line: got %b (seen=%0d) expected 0", resp_err, seen); end
    req_rd_i = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_drop_mid();
    int cyc, s_ar, s_rd, busy; bit seen;
    @(posedge clk); #1;
    s_ar = ar_q.size(); s_rd = rdw_q.size();
    addr_d = 64'h7000; req_rd_d = 1'b1;
    cyc = 0;
    while (rdw_q.size() - s_rd < 3 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    n_checks++; if (rdw_q.size() - s_rd < 3) begin n_fail++; $display("FAIL drop_reach_word3: got %0d words expected 3", rdw_q.size() - s_rd); end
    req_rd_d = 1'b0;
    wait_done(200, cyc, seen);
    n_checks++; if (!seen || grant !== 2'b10) begin n_fail++; $display("FAIL drop_done: got grant=%b (seen=%0d) expected 10", grant, seen); end
    n_checks++; if (ar_q.size() - s_ar != 16) begin n_fail++; $display("FAIL drop_beats: got %0d expected 16", ar_q.size() - s_ar); end
    busy = 0;
    repeat (6) begin @(posedge clk); #1; if (grant !== 2'b00 || arvalid || awvalid) busy++; end
    n_checks++; if (busy != 0) begin n_fail++; $display("FAIL drop_no_regrant: got %0d busy cycles expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(posedge clk); #1;
    addr_i = 64'h1040; req_rd_i = 1'b1;
    cyc = 0;
    while (!(rready === 1'b1 && word_idx === 4'd5) && cyc < 100) begin @(posedge clk); #1; cyc++; end
    n_checks++; if (rready !== 1'b1 || word_idx !== 4'd5) begin n_fail++;
      $display("FAIL rst_reach_word5: got rready=%b idx=%0d expected 1/5", rready, word_idx); end
    #1 arst = 1'b1;
    #1;
    n_checks++; if ({arvalid, awvalid, wvalid, bready, rready, rd_word_valid, done} !== 7'b0) begin n_fail++;
      $display("FAIL rst_valids_drop: got %b expected 0000000", {arvalid, awvalid, wvalid, bready, rready, rd_word_valid, done}); end
    req_rd_i = 1'b0;
    @(posedge clk); #2 arst = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (grant !== 2'b00 || word_idx !== 4'd0 || arvalid !== 1'b0) begin n_fail++;
      $display("FAIL rst_after_release: got grant=%b idx=%0d arvalid=%b expected 00/0/0", grant, word_idx, arvalid); end
  endtask

  initial begin
    arst = 1'b1;
    req_rd_i = 1'b0; req_rd_d = 1'b0; req_wb = 1'b0;
    addr_i = '0; addr_d = '0; addr_wb = '0;
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    rdata = '0; rresp = 2'b00; bresp = 2'b00;
    repeat (2) @(posedge clk);
    test_reset();
    test_read_line();
    test_priority();
    test_wb_delay();
    test_rresp_err();
    test_drop_mid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
